lpf_coeff_ctrl: RTL and testbench
=================================

Name: lpf_coeff_ctrl

Overview:
Coefficient configuration controller for the tapped-delay-line low-pass filter.
- Accepts a serial stream of TAP_NUM coefficients over a valid/ready handshake into a shadow bank.
- Commits the shadow bank atomically to the active bank on the next sample strobe, so the filter never sees a mix of old and new taps.
- The active bank drives the filter's packed coefficient input directly.

Parameters:
TAP_NUM, 16, number of filter taps; must be >= 2
COEFFICIENT_LEN, 16, width of one signed coefficient in bits

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
cfg_start_i  input  1  single-cycle pulse; begins (or restarts) a coefficient load
cfg_valid_i  input  1  coefficient beat valid
cfg_ready_o  output  1  controller accepts beat; high only in LOAD
cfg_data_i  input  COEFFICIENT_LEN  signed coefficient beat; first beat is tap 0
sample_valid_i  input  1  sample strobe, same cycle the filter shifts in a new sample
coeff_o  output  TAP_NUM*COEFFICIENT_LEN  packed active bank; tap k at bits [k*COEFFICIENT_LEN +: COEFFICIENT_LEN]
busy_o  output  1  high whenever state != IDLE
swap_done_o  output  1  one-cycle pulse, cycle after the active bank is updated
err_o  output  1  sticky protocol error flag, cleared only by rst

Behaviour:
- All sequential logic is on posedge clk. rst is sampled synchronously and has priority over everything.
- Reset values:
  - state = IDLE, beat counter = 0, shadow bank = 0.
  - Active bank = reset pattern (see Optional Feature).
  - cfg_ready_o = 0, busy_o = 0, swap_done_o = 0, err_o = 0.
- Beat counter is clog2(TAP_NUM) bits wide and counts 0..TAP_NUM-1. It never wraps past TAP_NUM-1.
- State IDLE:
  - cfg_ready_o = 0.
  - cfg_start_i=1 -> LOAD with counter = 0.
  - cfg_valid_i is ignored; no error is flagged.
- State LOAD:
  - cfg_ready_o = 1.
  - Each cycle with cfg_valid_i & cfg_ready_o: shadow[counter] <= cfg_data_i, counter++.
  - Beat accepted at counter == TAP_NUM-1 -> PEND.
- State PEND:
  - cfg_ready_o = 0; the shadow bank is frozen.
  - sample_valid_i=1 -> active bank <= shadow bank at that edge, then -> IDLE.
  - swap_done_o pulses in the following cycle.
  - coeff_o shows the new bank from the cycle after the strobe, so the sample registered at the strobe edge is the first one filtered with the new taps.
- cfg_start_i during LOAD:
  - Load restarts: counter = 0, stay in LOAD, err_o <= 1.
  - A simultaneous valid beat is dropped; start wins.
  - Shadow contents are not cleared; they are overwritten by the new beats.
- cfg_start_i during PEND:
  - Pending swap is abandoned: -> LOAD, counter = 0, err_o <= 1.
  - Active bank is unchanged, even if sample_valid_i is high in the same cycle (start wins).
- cfg_start_i in the same cycle as the final beat in LOAD: start wins, the beat is dropped, err_o <= 1.
- sample_valid_i outside PEND: no effect on this block.
- The active bank changes only on a PEND swap or on rst. Reset mid-load or mid-pend discards the shadow bank and restores the reset pattern to the active bank.
- No arithmetic on coefficient values; data is passed bit-exact as two's complement.
- Latency:
  - cfg_start_i to cfg_ready_o high: 1 cycle.
  - Minimum full load: TAP_NUM cycles plus the wait for a strobe.

Optional Feature:
Macro: LPF_COEFF_PASSTHRU_EN
- Defined: the reset active bank is a unit impulse, so the filter passes samples straight through after reset.
  - tap 0 = 2^(COEFFICIENT_LEN-1)-1 (max positive).
  - All other taps = 0.
- Not defined: reset active bank is all zeros, so filter output is 0 until the first load commits.
- Shadow bank resets to 0 in both cases.

Test Plan:
1. Reset, then hold 20 cycles with no stimulus -> coeff_o = 0 (impulse 0x7FFF at tap 0 with LPF_COEFF_PASSTHRU_EN); busy_o=0, cfg_ready_o=0, err_o=0.
2. Start pulse, 16 back-to-back beats 0x0001..0x0010, then sample_valid_i 5 cycles later -> coeff_o unchanged until the strobe; next cycle tap k = k+1; swap_done_o pulses once; busy_o falls; err_o=0.
3. Same load with cfg_valid_i toggling every other cycle -> exactly 16 beats accepted; cfg_ready_o drops on the cycle after beat 16 is accepted; tap order correct.
4. Load 8 beats of 0x1111, pulse cfg_start_i, load 16 beats of 0x2222, strobe -> all taps = 0x2222; err_o=1 and stays 1 until rst.
5. Complete load of 0x3333 reaches PEND; assert cfg_start_i together with sample_valid_i -> active bank unchanged; state LOAD; err_o=1; no swap_done_o pulse.
6. rst asserted mid-LOAD after 10 beats, then sample_valid_i pulses -> active bank holds the reset pattern; state IDLE; no swap occurs.

Source files
------------

// File: rtl/lpf_coeff_ctrl.sv
// Coefficient load/commit controller for the tapped-delay-line low-pass filter.
// Build option LPF_COEFF_PASSTHRU_EN: reset active bank is a unit impulse instead of zeros.
module lpf_coeff_ctrl #(
  parameter int unsigned TAP_NUM         = 16,
  parameter int unsigned COEFFICIENT_LEN = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cfg_start_i,
  input  logic                                 cfg_valid_i,
  output logic                                 cfg_ready_o,
  input  logic signed [COEFFICIENT_LEN-1:0]    cfg_data_i,
  input  logic                                 sample_valid_i,
  output logic [TAP_NUM*COEFFICIENT_LEN-1:0]   coeff_o,
  output logic                                 busy_o,
  output logic                                 swap_done_o,
  output logic                                 err_o
);

  localparam int unsigned BANK_W = TAP_NUM * COEFFICIENT_LEN;
  localparam int unsigned CNT_W  = (TAP_NUM > 1) ? $clog2(TAP_NUM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAP_NUM - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef LPF_COEFF_PASSTHRU_EN
  localparam logic [BANK_W-1:0] RESET_BANK =
    {{(BANK_W-COEFFICIENT_LEN){1'b0}}, 1'b0, {(COEFFICIENT_LEN-1){1'b1}}};
`else
  localparam logic [BANK_W-1:0] RESET_BANK = {BANK_W{1'b0}};
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BANK_W-1:0]   shadow_q, shadow_d;
  logic [BANK_W-1:0]   active_q, active_d;
  logic                err_q, err_d;
  logic                swap_q, swap_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  // Next-state, bank update and status decode; a start pulse always wins over beats and strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    err_d    = err_q;
    swap_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start_i) begin
          state_d = ST_LOAD;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (cfg_start_i) begin
          cnt_d = {CNT_W{1'b0}};
          err_d = 1'b1;
        end else if (cfg_valid_i) begin
          for (int k = 0; k < TAP_NUM; k++) begin
            shadow_d[k*COEFFICIENT_LEN +: COEFFICIENT_LEN] =
              (cnt_q == CNT_W'(k)) ? cfg_data_i
                                   : shadow_q[k*COEFFICIENT_LEN +: COEFFICIENT_LEN];
          end
          if (cnt_q == CNT_LAST) begin
            state_d = ST_PEND;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_PEND: begin
        if (cfg_start_i) begin
          state_d = ST_LOAD;
          cnt_d   = {CNT_W{1'b0}};
          err_d   = 1'b1;
        end else if (sample_valid_i) begin
          active_d = shadow_q;
          swap_d   = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_PEND;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    ready_d = (state_d == ST_LOAD);
    busy_d  = (state_d != ST_IDLE);
  end

  // State, banks and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      shadow_q <= {BANK_W{1'b0}};
      active_q <= RESET_BANK;
      err_q    <= 1'b0;
      swap_q   <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      err_q    <= err_d;
      swap_q   <= swap_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign coeff_o     = active_q;
  assign cfg_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign swap_done_o = swap_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_lpf_coeff_ctrl.sv
// Scoreboard bench for lpf_coeff_ctrl: directed plan items then randomized traffic.
module tb_lpf_coeff_ctrl;

  localparam int TAP_NUM = 16;
  localparam int CL      = 16;
  localparam int BW      = TAP_NUM * CL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          valid = 1'b0;
  logic          sample = 1'b0;
  logic [CL-1:0] data = '0;
  logic          ready, busy, swap, err;
  logic [BW-1:0] coeff;

  always #5 clk = ~clk;

  lpf_coeff_ctrl #(.TAP_NUM(TAP_NUM), .COEFFICIENT_LEN(CL)) dut (
    .clk(clk), .rst(rst), .cfg_start_i(start), .cfg_valid_i(valid),
    .cfg_ready_o(ready), .cfg_data_i(data), .sample_valid_i(sample),
    .coeff_o(coeff), .busy_o(busy), .swap_done_o(swap), .err_o(err)
  );

  int checks = 0;
  int errors = 0;

  typedef enum {M_IDLE, M_LOAD, M_PEND} mode_t;
  mode_t         mode = M_IDLE;
  logic [CL-1:0] beats[$];
  logic [BW-1:0] act_bank;
  bit            m_err = 1'b0;
  logic [BW-1:0] exp_q[$];

  function automatic logic [BW-1:0] reset_bank();
    logic [BW-1:0] b;
    logic [CL-1:0] mx;
    b  = '0;
    mx = '1;
    mx[CL-1] = 1'b0;
`ifdef LPF_COEFF_PASSTHRU_EN
    b[CL-1:0] = mx;
`endif
    return b;
  endfunction

  task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: a load is a list of accepted beats; commit copies the list into the bank.
  task automatic model_update();
    if (rst) begin
      mode = M_IDLE;
      beats.delete();
      act_bank = reset_bank();
      m_err = 1'b0;
    end else begin
      case (mode)
        M_IDLE: if (start) begin mode = M_LOAD; beats.delete(); end
        M_LOAD: begin
          if (start) begin
            m_err = 1'b1;
            beats.delete();
          end else if (valid) begin
            beats.push_back(data);
            if (beats.size() == TAP_NUM) mode = M_PEND;
          end
        end
        M_PEND: begin
          if (start) begin
            m_err = 1'b1;
            mode = M_LOAD;
            beats.delete();
          end else if (sample) begin
            for (int k = 0; k < TAP_NUM; k++) act_bank[k*CL +: CL] = beats[k];
            exp_q.push_back(act_bank);
            mode = M_IDLE;
          end
        end
        default: mode = M_IDLE;
      endcase
    end
  endtask

  task automatic cycle(input logic s, input logic v, input logic [CL-1:0] d, input logic smp);
    start = s; valid = v; data = d; sample = smp;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic load_beats(input int n, input logic [CL-1:0] base, input bit incr);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, incr ? base + CL'(i) : base, 1'b0);
  endtask

  // Monitor: status every cycle; each swap_done pulse pops one expected bank.
  always @(negedge clk) begin
    logic          exp_swap;
    logic [BW-1:0] exp_bank;
    exp_swap = (exp_q.size() > 0);
    check("busy", BW'(busy), BW'(mode != M_IDLE));
    check("ready", BW'(ready), BW'(mode == M_LOAD));
    check("err", BW'(err), BW'(m_err));
    check("coeff", coeff, act_bank);
    check("swap_done", BW'(swap), BW'(exp_swap));
    if (exp_swap) begin
      exp_bank = exp_q.pop_front();
      if (swap) check("swap_bank", coeff, exp_bank);
    end
  end

  initial begin
    act_bank = reset_bank();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;

    // 1: quiet after reset
    idle(20);
    // 2: back-to-back load, strobe 5 cycles later
    cycle(1'b1, 1'b0, '0, 1'b0);
    load_beats(16, 16'h0001, 1'b1);
    idle(5);
    cycle(1'b0, 1'b0, '0, 1'b1);
    idle(3);
    // 3: valid toggling every other cycle, keeps toggling into PEND
    cycle(1'b1, 1'b0, '0, 1'b0);
    begin
      int n;
      n = 0;
      for (int c = 0; c < 40; c++) begin
        bit v;
        bit acc;
        v = (c % 2 == 0);
        acc = v && (mode == M_LOAD);
        cycle(1'b0, v, CL'(n + 16'h0101), 1'b0);
        if (acc) n++;
      end
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    idle(2);
    // 4: restart mid-load
    cycle(1'b1, 1'b0, '0, 1'b0);
    load_beats(8, 16'h1111, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    load_beats(16, 16'h2222, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    idle(2);
    // 5: start together with strobe in PEND
    cycle(1'b1, 1'b0, '0, 1'b0);
    load_beats(16, 16'h3333, 1'b0);
    idle(2);
    cycle(1'b1, 1'b0, '0, 1'b1);
    idle(3);
    // start together with final beat drops the beat
    load_beats(15, 16'h4440, 1'b1);
    cycle(1'b1, 1'b1, 16'hBEEF, 1'b0);
    load_beats(16, 16'h8000, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    idle(2);
    // 6: reset mid-load
    cycle(1'b1, 1'b0, '0, 1'b0);
    load_beats(10, 16'h5550, 1'b1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    cycle(1'b0, 1'b0, '0, 1'b1);
    idle(2);
    cycle(1'b0, 1'b0, '0, 1'b1);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
            CL'($urandom), $urandom_range(0, 5) == 0);
    end
    rst = 1'b0;
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_swaps got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
